mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Parametrised memory-mapped I/O controller between the CPU's memory interface and the board switches/LEDs. It replaces fixed-width, purely combinational switch/LED address decoding with:
- a debounced, synchronised switch register;
- a writable and readable LED register;
- a sticky switch-change status flag;
- registered reads with a valid strobe.

All widths and addresses are parameters.

## Interface
- `SW_WIDTH`, 10, number of switch inputs
- `LED_WIDTH`, 8, number of LED outputs
- `DATA_WIDTH`, 16, CPU data bus width; must be ≥ `SW_WIDTH`, `LED_WIDTH`, 2
- `ADDR_WIDTH`, 9, CPU address width
- `LED_ADDR`, 9'h100, LED register address
- `SW_ADDR`, 9'h140, switch register address
- `STATUS_ADDR`, 9'h141, status register address; the three addresses must be distinct
- `DEBOUNCE`, 4, stable cycles required before a switch change commits; ≥ 1
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `mem_cmd` in 2: 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 treated as none
- `mem_addr` in `ADDR_WIDTH`: access address
- `write_data` in `DATA_WIDTH`: write data
- `sw_in` in `SW_WIDTH`: raw asynchronous switches
- `rd_data` out `DATA_WIDTH`: registered read data
- `rd_valid` out 1: high for one cycle when `rd_data` holds a hit read
- `led_out` out `LED_WIDTH`: LED register
- `sw_changed` out 1: sticky change flag (status bit 0)

## Operation
- **Reset** (asynchronous, immediate): the following are all 0, and stay 0 while `reset` is high:
  - both synchroniser stages, the candidate register, `sw_db`, and the counter;
  - `led_out`, `rd_data`, `rd_valid`, `sw_changed`.
- **Synchroniser:** two flops, `sw_in` → `s1` → `s2`.
- **Debouncer:** one shared counter and a `SW_WIDTH` candidate register `cand`. Per edge, in priority order:
  - `s2 != cand`: `cand` ← `s2`; counter ← 0.
  - else `cand != sw_db` and counter == `DEBOUNCE-1`: `sw_db` ← `cand`; counter ← 0; `sw_changed` ← 1.
  - else `cand != sw_db`: counter ← counter + 1.
  - else: counter holds at 0.
- **Counter width:** `$clog2(DEBOUNCE)` bits, minimum 1. It never wraps because it is compared before increment.
- **Hit:** `mem_addr` equals one of the three addresses and `mem_cmd` is read or write.
- **Write:**
  - `LED_ADDR`: `led_out` ← `write_data[LED_WIDTH-1:0]`.
  - `SW_ADDR` and `STATUS_ADDR`: ignored.
  - Miss: no state change.
- **Read, zero-extended to `DATA_WIDTH`:**
  - `SW_ADDR`: `sw_db`.
  - `LED_ADDR`: `led_out`.
  - `STATUS_ADDR`: bit0 = `sw_changed`; bit1 = (`cand != sw_db`), i.e. debounce in progress; other bits 0.
- **Status read side effect:** a read of `STATUS_ADDR` clears `sw_changed`. If a commit occurs on the same edge, set wins: the flag stays 1 and the read returns the pre-edge value.
- **Read miss or no command:** `rd_valid` ← 0; `rd_data` holds its previous value.
- **Same-address interactions:**
  - Read of `LED_ADDR` in the cycle after a write to it returns the new value.
  - Read of `SW_ADDR` on a commit edge returns the old `sw_db`.

## Timing
- **Read latency:** 1 cycle. A command sampled at edge N gives `rd_data`/`rd_valid` valid after edge N; `rd_valid` deasserts after edge N+1 unless another hit read occurs. Back-to-back reads every cycle are supported.
- **Write latency:** `led_out` updates at the sampling edge.
- **Switch latency:** `sw_in` stable from before edge 1 gives:
  - `s2` at edge 2;
  - `cand` at edge 3;
  - `sw_db` and `sw_changed` at edge 3+`DEBOUNCE` (edge 7 at default).
- **Bounce:** any `sw_in` toggle that reaches `s2` before commit restarts the count.
- **Reset mid-operation:** a pending debounce, pending read, and LED state are all discarded. After reset, a non-zero `sw_in` commits as a normal change and sets `sw_changed`.

## Test plan
- **Reset:** assert `reset` with `sw_in`=0 → all outputs 0; read of `STATUS_ADDR` → `rd_data`=16'h0000, `rd_valid`=1 one cycle later.
- **Switch commit:** deassert reset, `sw_in`=10'h00F, no bounce → `sw_db`=10'h00F and `sw_changed`=1 exactly 7 edges after first sample; read `SW_ADDR` → 16'h000F; read `STATUS_ADDR` → 16'h0001, then `sw_changed`=0.
- **Bounce:**
  - `sw_in` 10'h00F→10'h0F0 for 2 cycles, then back to 10'h00F → no commit, `sw_changed` stays 0.
  - Then 10'h0F0 held → commit after 3+4 edges; status bit1=1 during the wait.
- **LED write/readback:** write 16'hABCD to `LED_ADDR` → `led_out`=8'hCD next cycle; read `LED_ADDR` → 16'h00CD.
- **Misses:**
  - Write to `SW_ADDR` → `led_out` and `sw_db` unchanged.
  - Read of 9'h000 → `rd_valid`=0, `rd_data` unchanged.
  - `mem_cmd`=2'b11 to `LED_ADDR` → no effect.
- **Set-wins and reset:**
  - Status read on the commit edge → returns bit0=0, and `sw_changed`=1 afterward.
  - `reset` pulsed mid-debounce → counter/`cand` cleared, `led_out`=0.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/LED controller: synchronised, debounced switches, a read/write
// LED register, a sticky switch-change flag and registered single-cycle reads.
module mmio_io_ctrl #(
  parameter int unsigned            SW_WIDTH    = 10,
  parameter int unsigned            LED_WIDTH   = 8,
  parameter int unsigned            DATA_WIDTH  = 16,
  parameter int unsigned            ADDR_WIDTH  = 9,
  parameter logic [ADDR_WIDTH-1:0]  LED_ADDR    = 9'h100,
  parameter logic [ADDR_WIDTH-1:0]  SW_ADDR     = 9'h140,
  parameter logic [ADDR_WIDTH-1:0]  STATUS_ADDR = 9'h141,
  parameter int unsigned            DEBOUNCE    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [SW_WIDTH-1:0]   sw_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [LED_WIDTH-1:0]  led_out,
  output logic                  sw_changed
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  logic [SW_WIDTH-1:0]   s1, s2, cand, sw_db;
  logic [CntW-1:0]       cnt;
  logic                  is_rd, is_wr, hit_led, hit_sw, hit_status, hit;
  logic                  busy, commit, status_rd;
  logic [DATA_WIDTH-1:0] rd_next;

  assign is_rd      = (mem_cmd == 2'b01);
  assign is_wr      = (mem_cmd == 2'b10);
  assign hit_led    = (mem_addr == LED_ADDR);
  assign hit_sw     = (mem_addr == SW_ADDR);
  assign hit_status = (mem_addr == STATUS_ADDR);
  assign hit        = hit_led | hit_sw | hit_status;
  assign status_rd  = is_rd & hit_status;

  assign busy   = (cand != sw_db);
  // Commit only once the candidate has matched s2 for the full debounce window.
  assign commit = (s2 == cand) && busy && (cnt == CntMax);

  always_comb begin
    rd_next = '0;
    if (hit_sw) begin
      rd_next[SW_WIDTH-1:0] = sw_db;
    end else if (hit_led) begin
      rd_next[LED_WIDTH-1:0] = led_out;
    end else begin
      rd_next[1:0] = {busy, sw_changed};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      sw_db <= '0;
      cnt   <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (commit) begin
        sw_db <= cand;
        cnt   <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      if (is_wr && hit_led) begin
        led_out <= write_data[LED_WIDTH-1:0];
      end
      rd_valid <= is_rd && hit;
      if (is_rd && hit) begin
        rd_data <= rd_next;
      end
      // A commit on the same edge as a status read keeps the flag set.
      if (commit) begin
        sw_changed <= 1'b1;
      end else if (status_rd) begin
        sw_changed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: expected read data is queued at issue time and
// compared when rd_valid is seen; other outputs are checked directly.
module tb_mmio_io_ctrl;

  localparam logic [8:0] LedA = 9'h100;
  localparam logic [8:0] SwA  = 9'h140;
  localparam logic [8:0] StA  = 9'h141;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [9:0]  sw_in;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [7:0]  led_out;
  logic        sw_changed;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] sb[$];
  logic [15:0] last_rd = '0;

  mmio_io_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw_in      (sw_in),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .led_out    (led_out),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [8:0] addr, input logic [15:0] exp);
    mem_cmd  = 2'b01;
    mem_addr = addr;
    sb.push_back(exp);
    last_rd = exp;
    tick();
    mem_cmd = 2'b00;
  endtask

  task automatic do_cmd(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] d);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = d;
    tick();
    mem_cmd = 2'b00;
  endtask

  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        check("rd_data", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    mem_cmd    = 2'b00;
    mem_addr   = '0;
    write_data = '0;
    sw_in      = '0;
    repeat (3) tick();
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_sw_changed", 32'(sw_changed), 32'd0);
    reset = 1'b0;
    do_read(StA, 16'h0000);
    check("rd_valid_pulse", 32'(rd_valid), 32'd1);
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);

    // Clean commit: change sampled at edge 1, commit at edge 7.
    sw_in = 10'h00F;
    repeat (6) tick();
    check("commit_not_early", 32'(sw_changed), 32'd0);
    tick();
    check("commit_edge7", 32'(sw_changed), 32'd1);
    do_read(SwA, 16'h000F);
    do_read(StA, 16'h0001);
    check("status_clears", 32'(sw_changed), 32'd0);

    // Short bounce must not commit.
    sw_in = 10'h0F0;
    repeat (2) tick();
    sw_in = 10'h00F;
    repeat (10) tick();
    check("bounce_no_flag", 32'(sw_changed), 32'd0);
    do_read(SwA, 16'h000F);

    // Held change: status shows debounce in progress, commit at edge 7.
    sw_in = 10'h0F0;
    repeat (3) tick();
    do_read(StA, 16'h0002);
    repeat (2) tick();
    check("held_not_early", 32'(sw_changed), 32'd0);
    tick();
    check("held_commit", 32'(sw_changed), 32'd1);
    do_read(SwA, 16'h00F0);
    do_read(StA, 16'h0001);

    // LED write and read-back.
    do_cmd(2'b10, LedA, 16'hABCD);
    check("led_write", 32'(led_out), 32'h00CD);
    do_read(LedA, 16'h00CD);

    // Misses.
    do_cmd(2'b10, SwA, 16'hFFFF);
    check("wr_sw_led", 32'(led_out), 32'h00CD);
    do_read(SwA, 16'h00F0);
    do_cmd(2'b01, 9'h000, 16'h0000);
    check("miss_rd_valid", 32'(rd_valid), 32'd0);
    check("miss_rd_data", 32'(rd_data), 32'(last_rd));
    do_cmd(2'b11, LedA, 16'h1234);
    check("cmd11_led", 32'(led_out), 32'h00CD);
    check("cmd11_rd_valid", 32'(rd_valid), 32'd0);

    // Status read on the commit edge: set wins, read sees pre-edge flag.
    sw_in = 10'h0FF;
    repeat (6) tick();
    do_read(StA, 16'h0002);
    check("set_wins", 32'(sw_changed), 32'd1);
    do_read(StA, 16'h0001);

    // Reset during a pending debounce.
    sw_in = 10'h3FF;
    repeat (4) tick();
    reset = 1'b1;
    #2;
    check("mid_rst_led", 32'(led_out), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    do_read(StA, 16'h0000);
    repeat (5) tick();
    check("post_rst_not_early", 32'(sw_changed), 32'd0);
    tick();
    check("post_rst_commit", 32'(sw_changed), 32'd1);
    do_read(SwA, 16'h03FF);
    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
